// File: rtl/ni_packetizer_if.sv
// Packetizer bus bundle: FIFO pop side plus router flit handshake.
// master = packetizer view, slave = FIFO/router view.
interface ni_packetizer_if #(
  parameter int DSIZE = 32
);
  logic [DSIZE-1:0] fifo_rdata;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DSIZE+1:0] flit_data;
  logic             flit_valid;
  logic             flit_ready;
  logic             pkt_sent;
  logic             busy;

  modport master (
    input  fifo_rdata, fifo_empty, flit_ready,
    output fifo_rd_en, flit_data, flit_valid, pkt_sent, busy
  );

  modport slave (
    output fifo_rdata, fifo_empty, flit_ready,
    input  fifo_rd_en, flit_data, flit_valid, pkt_sent, busy
  );
endinterface

// File: rtl/ni_packetizer.sv
// NI injection packetizer: groups same-destination FIFO words into HEAD+BODY/TAIL packets.
// One FIFO word per 2 cycles; HEAD follows a full buffer by 1 cycle; flits held stable under stall.
module ni_packetizer #(
  parameter int         DSIZE    = 32,
  parameter int         MAX_BODY = 8,
  parameter int         TIMEOUT  = 16,
  parameter int         DEST_W   = 4,
  parameter logic [7:0] NODE_ID  = 8'd0
) (
  input  logic             clk,
  input  logic             reset,
  ni_packetizer_if.master  bus
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_HEAD    = 2'd2;
  localparam logic [1:0] S_BODY    = 2'd3;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;

  localparam int IDX_W = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DEST_W-1:0] cur_dest_q, cur_dest_d;
  logic [DSIZE-1:0]  pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              pkt_sent_q, pkt_sent_d;

  logic [DSIZE-1:0]  buf_q [MAX_BODY];
  logic              buf_we;
  logic [IDX_W-1:0]  buf_waddr;
  logic [DSIZE-1:0]  buf_wdat;

  logic              rd_en;
  logic              is_tail;
  logic [DEST_W-1:0] word_dest;
  logic [31:0]       hdr;
  logic [DSIZE+1:0]  flit_dat;

  assign word_dest = bus.fifo_rdata[DEST_W-1:0];
  assign is_tail   = (idx_q == cnt_q - 8'd1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    cur_dest_d = cur_dest_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    pkt_sent_d = 1'b0;
    rd_en      = 1'b0;
    buf_we     = 1'b0;
    buf_waddr  = cnt_q[IDX_W-1:0];
    buf_wdat   = bus.fifo_rdata;

    case (state_q)
      S_COLLECT: begin
        if (cnt_q == 8'(MAX_BODY)) begin
          state_d = S_HEAD;
        end else if (!bus.fifo_empty) begin
          rd_en   = 1'b1;
          timer_d = '0;
          state_d = S_WAIT;
        end else if (cnt_q != 8'd0) begin
          // Idle flush of a partial packet once the FIFO stays dry long enough
          if (timer_q == TMR_W'(TIMEOUT - 1)) state_d = S_HEAD;
          else                                timer_d = timer_q + 1'b1;
        end else begin
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0 || word_dest == cur_dest_q) begin
          buf_we     = 1'b1;
          cnt_d      = cnt_q + 8'd1;
          cur_dest_d = word_dest;
          state_d    = S_COLLECT;
        end else begin
          pend_d     = bus.fifo_rdata;
          pend_vld_d = 1'b1;
          state_d    = S_HEAD;
        end
      end
      S_HEAD: begin
        if (bus.flit_ready) begin
          idx_d   = 8'd0;
          state_d = S_BODY;
        end
      end
      default: begin
        if (bus.flit_ready) begin
          if (is_tail) begin
            pkt_sent_d = 1'b1;
            cnt_d      = 8'd0;
            timer_d    = '0;
            state_d    = S_COLLECT;
            // A word held back by a destination change opens the next packet
            if (pend_vld_q) begin
              buf_we     = 1'b1;
              buf_waddr  = '0;
              buf_wdat   = pend_q;
              cnt_d      = 8'd1;
              cur_dest_d = pend_q[DEST_W-1:0];
              pend_vld_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_COLLECT;
      cnt_q      <= 8'd0;
      idx_q      <= 8'd0;
      timer_q    <= '0;
      cur_dest_q <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pkt_sent_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      cur_dest_q <= cur_dest_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pkt_sent_q <= pkt_sent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[buf_waddr] <= buf_wdat;
  end

  always_comb begin
    hdr      = {cnt_q, NODE_ID, 8'h00, 8'(cur_dest_q)};
    flit_dat = '0;
    case (state_q)
      S_HEAD:  flit_dat = {T_HEAD, DSIZE'(hdr)};
      S_BODY:  flit_dat = {(is_tail ? T_TAIL : T_BODY), buf_q[idx_q[IDX_W-1:0]]};
      default: flit_dat = '0;
    endcase
  end

  assign bus.flit_data  = flit_dat;
  assign bus.flit_valid = (state_q == S_HEAD) || (state_q == S_BODY);
  assign bus.fifo_rd_en = rd_en && !reset;
  assign bus.pkt_sent   = pkt_sent_q;
  assign bus.busy       = (cnt_q != 8'd0) || pend_vld_q || (state_q != S_COLLECT);

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: FIFO model, ready driver, flit monitor and packet-level reference model.
module tb_ni_packetizer;
  localparam int MAXB = 8;
  localparam int TMO  = 16;

  logic clk;
  logic reset;
  ni_packetizer_if #(.DSIZE(32)) bus ();

  ni_packetizer #(.DSIZE(32), .MAX_BODY(MAXB), .TIMEOUT(TMO), .DEST_W(4), .NODE_ID(8'h00)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int sent_cnt = 0;
  int exp_npk = 0;
  logic [31:0] fq[$];
  logic [31:0] words_q[$];
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  int got_cyc[$];
  int rd_cyc_q[$];
  logic stall_prev = 1'b0;
  logic [33:0] prev_dat;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // FIFO model: a pop seen in a cycle delivers its word in the next cycle
  initial begin
    logic pop;
    bus.fifo_rdata = '0;
    bus.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      pop = bus.fifo_rd_en;
      @(posedge clk);
      #1;
      if (pop && fq.size() > 0) bus.fifo_rdata = fq.pop_front();
      bus.fifo_empty = (fq.size() == 0);
    end
  end

  initial begin
    bus.flit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.flit_ready = 1'b1;
        2:       bus.flit_ready = 1'($urandom_range(0, 1));
        default: bus.flit_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        rd_cyc_q.push_back(cyc);
        check("rd_en_legal", {62'd0, bus.fifo_empty, bus.flit_valid}, 64'd0);
      end
      if (stall_prev) check("stall_hold", {bus.flit_valid, bus.flit_data}, {1'b1, prev_dat});
      if (bus.flit_valid && bus.flit_ready) begin
        got_q.push_back(bus.flit_data);
        got_cyc.push_back(cyc);
      end
      if (bus.pkt_sent) sent_cnt++;
      stall_prev = bus.flit_valid && !bus.flit_ready;
      prev_dat   = bus.flit_data;
    end
  end

  // Packet-level model: runs of equal destination, chopped into MAXB-sized packets
  task automatic model();
    int i;
    int j;
    logic [3:0] d;
    exp_q.delete();
    exp_npk = 0;
    i = 0;
    while (i < words_q.size()) begin
      d = words_q[i][3:0];
      j = i;
      while (j < words_q.size() && words_q[j][3:0] == d && (j - i) < MAXB) j++;
      exp_q.push_back({2'b01, 8'(j - i), 8'h00, 8'h00, 4'h0, d});
      for (int k = i; k < j; k++) exp_q.push_back({(k == j - 1) ? 2'b10 : 2'b00, words_q[k]});
      exp_npk++;
      i = j;
    end
  endtask

  task automatic run_words(input int rmode, input string tag);
    int c;
    model();
    got_q.delete();
    got_cyc.delete();
    rd_cyc_q.delete();
    sent_cnt = 0;
    rdy_mode = rmode;
    @(negedge clk);
    foreach (words_q[i]) fq.push_back(words_q[i]);
    c = 0;
    while (c < 4000 && got_q.size() < exp_q.size()) begin
      @(negedge clk);
      c++;
    end
    repeat (40) @(negedge clk);
    check({tag, "_nflits"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check({tag, "_flit"}, 64'(got_q[i]), 64'(exp_q[i]));
    check({tag, "_pkt_sent"}, 64'(sent_cnt), 64'(exp_npk));
    check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic make_word(input logic [3:0] d);
    words_q.push_back({16'($urandom), 12'($urandom), d});
  endtask

  typedef struct {
    int         n;
    logic [3:0] da;
    logic [3:0] db;
    int         sw;
    int         rmode;
    int         exp_pkts;
    logic [31:0] exp_head0;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int heads;
    int c;
    logic [3:0] d;
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int heads;
    int c;
    logic [3:0] d;
    vecs[0] = '{8,  4'd3,  4'd3,  8,  1, 1, 32'h08000003};
    vecs[1] = '{3,  4'd2,  4'd5,  2,  1, 2, 32'h02000002};
    vecs[2] = '{20, 4'd1,  4'd1,  20, 1, 3, 32'h08000001};
    vecs[3] = '{4,  4'd9,  4'd9,  4,  2, 1, 32'h04000009};
    vecs[4] = '{10, 4'd4,  4'd12, 3,  2, 2, 32'h03000004};
    vecs[5] = '{17, 4'd15, 4'd15, 17, 1, 3, 32'h0800000F};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(bus.flit_valid), 64'd0);
    check("rst_data", 64'(bus.flit_data), 64'd0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_pkt_sent", 64'(bus.pkt_sent), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // Lone word: pop cycle, capture cycle, then TIMEOUT idle cycles before HEAD
    words_q.delete();
    make_word(4'd7);
    run_words(1, "timeout");
    if (got_cyc.size() > 0 && rd_cyc_q.size() > 0)
      check("timeout_latency", 64'(got_cyc[0] - rd_cyc_q[0]), 64'(TMO + 2));
    else
      check("timeout_seen", 64'(got_cyc.size()), 64'd2);

    for (int v = 0; v < 6; v++) begin
      words_q.delete();
      for (int i = 0; i < vecs[v].n; i++) make_word((i < vecs[v].sw) ? vecs[v].da : vecs[v].db);
      run_words(vecs[v].rmode, $sformatf("vec%0d", v));
      heads = 0;
      foreach (got_q[i]) if (got_q[i][33:32] == 2'b01) heads++;
      check($sformatf("vec%0d_pkts", v), 64'(heads), 64'(vecs[v].exp_pkts));
      check($sformatf("vec%0d_sent", v), 64'(sent_cnt), 64'(vecs[v].exp_pkts));
      if (got_q.size() > 0) check($sformatf("vec%0d_head0", v), 64'(got_q[0]), {30'd0, 2'b01, vecs[v].exp_head0});
    end

    // Reset while BODY flits are streaming
    got_q.delete();
    sent_cnt = 0;
    rdy_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) fq.push_back({16'hDEAD, 12'h000, 4'd6});
    c = 0;
    while (c < 200 && !(bus.flit_valid && bus.flit_data[33:32] != 2'b01)) begin
      @(negedge clk);
      c++;
    end
    check("rstmid_reached_body", 64'(bus.flit_valid), 64'd1);
    rdy_mode = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_valid", 64'(bus.flit_valid), 64'd0);
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    check("rstmid_no_tail", 64'(sent_cnt), 64'd0);
    words_q.delete();
    make_word(4'd3);
    make_word(4'd3);
    run_words(1, "after_rst");

    for (int r = 0; r < 8; r++) begin
      words_q.delete();
      d = 4'($urandom_range(0, 2));
      c = $urandom_range(1, 30);
      for (int i = 0; i < c; i++) begin
        if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 2));
        make_word(d);
      end
      run_words(2, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
